muldiv_ctrl: RTL and testbench

Sequencing controller for the core's shared multiply/divide unit and the architectural HI/LO registers.
- Accepts one HI/LO-class instruction at a time from the execute stage and launches the external multiplier/divider.
- Waits for the unit's completion pulse, then commits or accumulates the result into HI/LO.
- Stalls MFHI/MFLO while a write is pending and discards results of flushed operations.

---
 rtl/muldiv_ctrl.sv | 179 +++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// Sequencer between the execute stage, the shared multiply/divide unit and HI/LO.
// One HI/LO-class op in flight at a time; flushed ops are drained, never written back.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        unit_start,
  output logic [1:0]  unit_op,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  input  logic        unit_done,
  input  logic [31:0] unit_hi,
  input  logic [31:0] unit_lo,
  input  logic        rd_req,
  output logic        rd_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        mul_valid,
  output logic [31:0] mul_result
);

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MUL   = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;
  localparam logic [3:0] OP_MTHI  = 4'd10;
  localparam logic [3:0] OP_MTLO  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACC   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      state_r, state_next_s;
  logic [3:0]  op_r;
  logic [1:0]  unit_op_r;
  logic [31:0] unit_a_r, unit_b_r, hi_r, lo_r, mul_result_r;
  logic [63:0] prod_r, acc_sum_s;
  logic        start_r, ready_r, mul_valid_r;
  logic        accept_s, launch_s, done_ok_s, commit_s, mul_fin_s, capture_s, acc_s;
  logic        op_legal_s, is_move_s, div_zero_s, rd_stall_s;

  function automatic logic is_commit_op(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

  function automatic logic is_acc_op(input logic [3:0] op);
    return (op >= OP_MADD) && (op <= OP_MSUBU);
  endfunction

  function automatic logic is_sub_op(input logic [3:0] op);
    return (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic [1:0] unit_op_of(input logic [3:0] op);
    case (op)
      OP_MULT, OP_MUL, OP_MADD, OP_MSUB: return 2'd0;
      OP_MULTU, OP_MADDU, OP_MSUBU:      return 2'd1;
      OP_DIV:                            return 2'd2;
      OP_DIVU:                           return 2'd3;
      default:                           return 2'd0;
    endcase
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state logic; a done coinciding with flush is treated as already drained
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE:  state_next_s = launch_s ? ST_WAIT : ST_IDLE;
      ST_WAIT: begin
        if (flush) begin
          state_next_s = unit_done ? ST_IDLE : ST_DRAIN;
        end else if (unit_done) begin
          state_next_s = is_acc_op(op_r) ? ST_ACC : ST_IDLE;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_ACC:   state_next_s = ST_IDLE;
      ST_DRAIN: state_next_s = unit_done ? ST_IDLE : ST_DRAIN;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // output/control decode
  always_comb begin
    op_legal_s = (req_op >= OP_MULT) && (req_op <= OP_MTLO);
    accept_s   = req_valid && (state_r == ST_IDLE) && !flush && op_legal_s;
    is_move_s  = (req_op == OP_MTHI) || (req_op == OP_MTLO);
    div_zero_s = ((req_op == OP_DIV) || (req_op == OP_DIVU)) && (req_b == 32'd0);
    launch_s   = accept_s && !is_move_s && !div_zero_s;
    done_ok_s  = (state_r == ST_WAIT) && unit_done && !flush;
    commit_s   = done_ok_s && is_commit_op(op_r);
    mul_fin_s  = done_ok_s && (op_r == OP_MUL);
    capture_s  = done_ok_s && is_acc_op(op_r);
    acc_s      = (state_r == ST_ACC) && !flush;
    rd_stall_s = rd_req && ((state_r == ST_WAIT) || (state_r == ST_ACC));
  end

  // 64-bit accumulate, wrapping modulo 2^64
  always_comb begin
    if (is_sub_op(op_r)) begin
      acc_sum_s = {hi_r, lo_r} - prod_r;
    end else begin
      acc_sum_s = {hi_r, lo_r} + prod_r;
    end
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      op_r         <= OP_NOP;
      unit_op_r    <= 2'd0;
      unit_a_r     <= 32'd0;
      unit_b_r     <= 32'd0;
      start_r      <= 1'b0;
      ready_r      <= 1'b1;
      hi_r         <= 32'd0;
      lo_r         <= 32'd0;
      prod_r       <= 64'd0;
      mul_valid_r  <= 1'b0;
      mul_result_r <= 32'd0;
    end else begin
      ready_r     <= (state_next_s == ST_IDLE);
      start_r     <= launch_s;
      mul_valid_r <= mul_fin_s;
      if (launch_s) begin
        op_r      <= req_op;
        unit_op_r <= unit_op_of(req_op);
        unit_a_r  <= req_a;
        unit_b_r  <= req_b;
      end
      if (commit_s) begin
        {hi_r, lo_r} <= {unit_hi, unit_lo};
      end else if (acc_s) begin
        {hi_r, lo_r} <= acc_sum_s;
      end else if (accept_s) begin
        if (req_op == OP_MTHI) hi_r <= req_a;
        if (req_op == OP_MTLO) lo_r <= req_a;
      end
      if (capture_s) prod_r <= {unit_hi, unit_lo};
      if (mul_fin_s) mul_result_r <= unit_lo;
    end
  end

  assign req_ready  = ready_r;
  assign unit_start = start_r;
  assign unit_op    = unit_op_r;
  assign unit_a     = unit_a_r;
  assign unit_b     = unit_b_r;
  assign rd_stall   = rd_stall_s;
  assign hi         = hi_r;
  assign lo         = lo_r;
  assign mul_valid  = mul_valid_r;
  assign mul_result = mul_result_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl with a behavioural mul/div unit of fixed latency.
module tb_muldiv_ctrl;
  localparam int MAX_LAT = 40;
  localparam int UNIT_DLY = 5;  // unit_done arrives this many cycles after unit_start

  logic        clk = 1'b0;
  logic        reset, req_valid, flush, unit_done, rd_req;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b, unit_hi, unit_lo;
  logic        req_ready, unit_start, rd_stall, mul_valid;
  logic [1:0]  unit_op;
  logic [31:0] unit_a, unit_b, hi, lo, mul_result;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cnt;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .flush(flush),
    .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
    .unit_done(unit_done), .unit_hi(unit_hi), .unit_lo(unit_lo), .rd_req(rd_req),
    .rd_stall(rd_stall), .hi(hi), .lo(lo), .mul_valid(mul_valid), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present one request for a single cycle; returns at the next negedge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!req_ready && n < MAX_LAT + 10) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Behavioural multiply/divide unit
  initial begin
    logic        pending;
    int          left;
    logic [31:0] ma, mb;
    logic [1:0]  mop;
    logic [63:0] p;
    logic signed [63:0] sa, sb;
    pending = 1'b0; left = 0; ma = '0; mb = '0; mop = '0;
    unit_done = 1'b0; unit_hi = '0; unit_lo = '0;
    forever begin
      @(negedge clk);
      unit_done = 1'b0;
      if (pending) begin
        if (left == 0) begin
          pending = 1'b0;
          unit_done = 1'b1;
          sa = {{32{ma[31]}}, ma};
          sb = {{32{mb[31]}}, mb};
          case (mop)
            2'd0: begin p = 64'(sa * sb); unit_hi = p[63:32]; unit_lo = p[31:0]; end
            2'd1: begin p = {32'd0, ma} * {32'd0, mb}; unit_hi = p[63:32]; unit_lo = p[31:0]; end
            2'd2: begin unit_lo = $signed(ma) / $signed(mb); unit_hi = $signed(ma) % $signed(mb); end
            default: begin unit_lo = ma / mb; unit_hi = ma % mb; end
          endcase
        end else begin
          left--;
        end
      end
      if (unit_start) begin
        pending = 1'b1; left = UNIT_DLY - 1; ma = unit_a; mb = unit_b; mop = unit_op;
      end
    end
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = '0; req_b = '0;
    flush = 1'b0; rd_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", hi, 64'd0);
    chk("rst_lo", lo, 64'd0);
    chk("rst_ready", req_ready, 64'd1);
    chk("rst_ctl", {unit_start, mul_valid, mul_result, unit_a, unit_b}, 64'd0);
    rd_req = 1'b1; #1 chk("rst_stall", rd_stall, 64'd0); rd_req = 1'b0;

    // MULT -7 * 3
    issue(4'd1, 32'hFFFF_FFF9, 32'd3);
    chk("mult_start", unit_start, 64'd1);
    chk("mult_uop", unit_op, 64'd0);
    chk("mult_ops", {unit_a, unit_b}, 64'hFFFF_FFF9_0000_0003);
    wait_ready(cnt);
    chk("mult_busy", cnt, 64'd6);
    chk("mult_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // DIVU 100 / 7 with MFHI stalled during WAIT
    issue(4'd4, 32'd100, 32'd7);
    chk("divu_uop", unit_op, 64'd3);
    rd_req = 1'b1; cnt = 0; #1;
    while (rd_stall && cnt < MAX_LAT + 10) begin cnt++; @(negedge clk); #1; end
    chk("divu_stall", cnt, 64'd6);
    rd_req = 1'b0;
    chk("divu_res", {hi, lo}, {32'd2, 32'd14});
    @(negedge clk);

    // MTHI/MTLO then MADDU with carry into HI
    issue(4'd10, 32'h1, 32'd0);
    chk("mthi", hi, 64'h1);
    chk("mthi_ready", req_ready, 64'd1);
    issue(4'd11, 32'hFFFF_FFFF, 32'd0);
    chk("mtlo", lo, 64'hFFFF_FFFF);
    issue(4'd7, 32'd1, 32'd1);
    chk("maddu_uop", unit_op, 64'd1);
    wait_ready(cnt);
    chk("maddu_busy", cnt, 64'd7);
    chk("maddu_res", {hi, lo}, 64'h0000_0002_0000_0000);

    // MSUB of a negative product
    issue(4'd8, 32'd3, 32'hFFFF_FFFF);
    chk("msub_uop", unit_op, 64'd0);
    wait_ready(cnt);
    chk("msub_res", {hi, lo}, 64'h0000_0002_0000_0003);

    // MULT flushed two cycles after accept
    issue(4'd1, 32'd5, 32'd5);
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_op = 4'd10; req_a = 32'hDEAD;
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    rd_req = 1'b1; #1 chk("drain_stall", rd_stall, 64'd0); rd_req = 1'b0;
    chk("drain_busy", req_ready, 64'd0);
    wait_ready(cnt);
    chk("drain_len", cnt, 64'd4);
    chk("flush_keep", {hi, lo}, 64'h0000_0002_0000_0003);
    issue(4'd11, 32'h77, 32'd0);
    chk("post_drain_acc", lo, 64'h77);

    // no accept while flush is high in IDLE
    flush = 1'b1;
    issue(4'd10, 32'hBAD, 32'd0);
    flush = 1'b0;
    chk("flush_idle", hi, 64'd2);

    // DIV by zero: no launch
    issue(4'd3, 32'd9, 32'd0);
    chk("div0_start", unit_start, 64'd0);
    chk("div0_ready", req_ready, 64'd1);
    chk("div0_keep", {hi, lo}, 64'h0000_0002_0000_0077);

    // signed DIV -7 / 2
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    chk("div_uop", unit_op, 64'd2);
    wait_ready(cnt);
    chk("div_res", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    // MUL leaves HI/LO alone
    issue(4'd10, 32'd5, 32'd0);
    issue(4'd11, 32'd6, 32'd0);
    issue(4'd5, 32'h1_0000, 32'h1_0000);
    cnt = 0;
    while (!mul_valid && cnt < MAX_LAT + 10) begin cnt++; @(negedge clk); end
    chk("mul_lat", cnt, 64'd6);
    chk("mul_res", mul_result, 64'd0);
    chk("mul_keep", {hi, lo}, 64'h0000_0005_0000_0006);
    @(negedge clk);
    chk("mul_pulse", mul_valid, 64'd0);
    issue(4'd5, 32'h1_0001, 32'd3);
    cnt = 0;
    while (!mul_valid && cnt < MAX_LAT + 10) begin cnt++; @(negedge clk); end
    chk("mul2_res", mul_result, 64'h3_0003);

    // reset mid-operation, then a stray unit_done
    issue(4'd2, 32'd2, 32'd3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_ready", req_ready, 64'd1);
    chk("mid_rst_regs", {hi, lo}, 64'd0);
    chk("mid_rst_ua", unit_a, 64'd0);
    repeat (5) @(negedge clk);
    chk("stray_done", {hi, lo}, 64'd0);
    chk("stray_ready", req_ready, 64'd1);

    // op codes 12..15 behave as NOP
    issue(4'd12, 32'd1, 32'd1);
    chk("nop_start", unit_start, 64'd0);
    chk("nop_ready", req_ready, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
